// File: rtl/fd2e_scan_ctrl.sv
// fd2e_scan_ctrl: scan-chain sequencer for fd2e scan flip-flop chains.
// Shifts in a pattern, optionally fires one functional capture strobe,
// and shifts the chain contents back out into unload_data.
// Optional feature macro: SCAN_CAPTURE_EN (adds CAPTURE + UNLOAD phases).
// Ports:
//   sys_clk, cd (async active-low clear)
//   start, load_data[CHAIN_LEN], so, func_cp_in  (inputs)
//   cp, te, ti, busy, done, unload_data[CHAIN_LEN] (outputs)
module fd2e_scan_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CP_DIV    = 4
) (
    input  logic                 sys_clk,
    input  logic                 cd,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 so,
    input  logic                 func_cp_in,
    output logic                 cp,
    output logic                 te,
    output logic                 ti,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data
);

    localparam int TW = (CP_DIV > 1) ? $clog2(CP_DIV) : 1;
    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
`ifdef SCAN_CAPTURE_EN
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] UNLOAD  = 2'd3;
`endif

    localparam logic [TW-1:0] TIMER_LAST = TW'(CP_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CHAIN_LEN - 1);

    logic [1:0]           state;
    logic [TW-1:0]        timer;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] sreg;
    logic                 strobe;
    logic                 last;
    logic                 sample;

    // All scan outputs decode directly from registered state, so they are
    // settled for the whole strobe period and change only at strobe edges.
    assign strobe = (state != IDLE) && (timer == TIMER_LAST);
    assign last   = (cnt == CNT_LAST);
    assign busy   = (state != IDLE);
    assign cp     = busy ? strobe : func_cp_in;
    assign ti     = (state == SHIFT) && sreg[CHAIN_LEN-1];

`ifdef SCAN_CAPTURE_EN
    assign te     = (state == SHIFT) || (state == UNLOAD);
    assign sample = (state == UNLOAD);
`else
    // Without capture the old chain contents fall out of so while the new
    // pattern is shifted in.
    assign te     = (state == SHIFT);
    assign sample = (state == SHIFT);
`endif

    always_ff @(posedge sys_clk or negedge cd) begin
        if (!cd) begin
            state       <= IDLE;
            timer       <= '0;
            cnt         <= '0;
            sreg        <= '0;
            done        <= 1'b0;
            unload_data <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sreg  <= load_data;
                    timer <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
            end else begin
                timer <= strobe ? '0 : timer + TW'(1);
                if (strobe) begin
                    // so still shows the pre-shift value on this edge
                    if (sample)
                        unload_data[CHAIN_LEN-1-int'(cnt)] <= so;
                    cnt <= last ? '0 : cnt + CW'(1);
                    case (state)
                        SHIFT: begin
                            sreg <= sreg << 1;
                            if (last) begin
`ifdef SCAN_CAPTURE_EN
                                state <= CAPTURE;
`else
                                state <= IDLE;
                                done  <= 1'b1;
`endif
                            end
                        end
`ifdef SCAN_CAPTURE_EN
                        CAPTURE: begin
                            cnt   <= '0;
                            state <= UNLOAD;
                        end
                        UNLOAD: begin
                            if (last) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
`endif
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/fd2e_scan_ctrl.md
# fd2e_scan_ctrl

Scan-chain sequencer for chains of `fd2e` scan flip-flops in the netlist-derived core. Drives the chain's shared `cp` strobe, `te` and `ti` on `sys_clk` to serially load a pattern, optionally fire one functional capture strobe, and serially unload the result. When idle, it passes the system's functional clock-enable through to the chain untouched.

## Interface
- `CHAIN_LEN`, 16: number of `fd2e` stages in the chain (≥2).
- `CP_DIV`, 4: `sys_clk` cycles per `cp` strobe during scan (≥2).

- `sys_clk`  in  1  system clock; all state updates on its rising edge.
- `cd`  in  1  asynchronous, active-low reset/clear.
- `start`  in  1  begin a scan sequence; sampled only in IDLE.
- `load_data`  in  CHAIN_LEN  pattern; latched on the accepting edge.
- `so`  in  1  `q` of the last chain stage (stage CHAIN_LEN-1).
- `func_cp_in`  in  1  functional `cp` enable from the system.
- `cp`  out  1  chain `cp` enable.
- `te`  out  1  chain test-enable.
- `ti`  out  1  chain scan input (feeds stage 0).
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `unload_data`  out  CHAIN_LEN  chain contents collected in the final shift phase.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD.
- IDLE: `te`=0, `ti`=0, `busy`=0, `cp`=`func_cp_in` (combinational passthrough). If `start`=1: latch `load_data`, clear timer and bit counter, go to SHIFT.
- Strobe timer: counts 0..CP_DIV-1 in every non-IDLE state. `cp`=1 for exactly the one cycle where timer=CP_DIV-1; otherwise 0. While busy, `func_cp_in` is ignored.
- SHIFT: `te`=1. `ti` presents load bits MSB first (`load_data[CHAIN_LEN-1]` at strobe 1). After strobe CHAIN_LEN, stage k holds `load_data[k]`. Go to CAPTURE.
- CAPTURE: `te`=0, `ti`=0, one strobe, which clocks functional `d` into every stage. Go to UNLOAD.
- UNLOAD: `te`=1, `ti`=0. On each strobe edge, sample `so`. The strobe-j sample (j=1..CHAIN_LEN) is written to `unload_data[CHAIN_LEN-j]`, so `unload_data[k]` equals the pre-unload contents of stage k. After strobe CHAIN_LEN, go to IDLE with `done`=1.
- `so` is sampled on the same edge the strobe clocks the chain, i.e. it captures the pre-shift value.
- `start` while busy is ignored. `start` in the `done` cycle is accepted because the block is already in IDLE.
- `unload_data` holds its value until the next sequence's first UNLOAD sample overwrites it.

## Timing
- Reset (`cd`=0, asynchronous): state IDLE, timer and counter 0, `te`=0, `ti`=0, `busy`=0, `done`=0, `unload_data`=0, `cp` follows `func_cp_in`.
- Reset mid-sequence aborts immediately. `done` is not pulsed and the chain is left partially shifted.
- `busy` rises on the cycle after the accepting edge.
- Strobe j occurs in the cycle ending at edge E0 + j·CP_DIV, where E0 is the accepting edge.
- `done` and `busy` fall are registered at the last strobe edge.
- Full sequence: `done` high (2·CHAIN_LEN+1)·CP_DIV cycles after E0.
- Scan outputs `te`, `ti` and the strobe portion of `cp` are registered and stable at least CP_DIV-1 cycles before each strobe.

## Configuration
- `SCAN_CAPTURE_EN` defined: full IDLE→SHIFT→CAPTURE→UNLOAD sequence as above.
- `SCAN_CAPTURE_EN` undefined: CAPTURE and UNLOAD are removed. In SHIFT, `so` is sampled into `unload_data` with the same indexing, returning the chain's old contents while loading the new pattern. `done` is high CHAIN_LEN·CP_DIV cycles after E0.

## Test plan
Bench: CHAIN_LEN=4, CP_DIV=2, 4 `fd2e` model stages with `d`=~`q` per stage.
- Reset: hold `cd`=0 with `func_cp_in` toggling → `te`/`ti`/`busy`/`done`=0, `unload_data`=0, `cp` mirrors `func_cp_in`.
- Full run (`SCAN_CAPTURE_EN`): `load_data`=4'b1011, pulse `start` → chain equals 1011 after strobe 4, `unload_data`=4'b0100, `done` 18 cycles after E0.
- Shift-only build: chain preset 4'b0110, `load_data`=4'b1001 → `unload_data`=4'b0110, chain=1001, `done` 8 cycles after E0.
- `start` held high for 40 cycles → back-to-back runs, each `done` exactly 19 cycles apart (18 plus the accepting IDLE cycle). Mid-run starts are ignored.
- `cd` pulsed low at the strobe-3 cycle → `busy`/`te` drop that cycle, no `done` pulse. A subsequent `start` runs normally.
- During busy, toggle `func_cp_in` every cycle → `cp` pulses only on strobe cycles (every 2nd cycle).
